// File: rtl/avl_bus_arbiter_pkg.sv
// Shared types and helpers for the Avalon bus arbiter.
//   MASTER_NUM  : number of master ports. Rebuild this package to change it.
//   master_id_t : index of one master port.
//   arb_state_e : arbiter states (ARB = free to arbitrate, HOLD = locked on one master).
//   pick_t      : result of a round-robin search.
//   rr_pick     : first set request at or above ptr, wrapping modulo MASTER_NUM.
//   rr_next     : ptr + 1, wrapping modulo MASTER_NUM.
package avl_arb_pkg;
  localparam int MASTER_NUM = 4;
  localparam int MID_W      = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  typedef logic [MID_W-1:0] master_id_t;
  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} arb_state_e;

  typedef struct packed {
    logic       vld;
    master_id_t id;
  } pick_t;

  // Rotate the request vector so that ptr lands on bit 0. The loop walks
  // downward, so the lowest rotated position (closest to ptr) wins.
  function automatic pick_t rr_pick(input logic [MASTER_NUM-1:0] req,
                                    input master_id_t ptr);
    logic [2*MASTER_NUM-1:0] dbl;
    pick_t p;
    p   = '0;
    dbl = {req, req} >> ptr;
    for (int k = MASTER_NUM - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        p.vld = 1'b1;
        p.id  = master_id_t'((int'(ptr) + k) % MASTER_NUM);
      end
    end
    return p;
  endfunction

  function automatic master_id_t rr_next(input master_id_t id);
    return (int'(id) == MASTER_NUM - 1) ? '0 : id + 1'b1;
  endfunction
endpackage

// File: rtl/avl_bus_arbiter_if.sv
// Avalon-style command/response bundle, N ports wide.
//   address/byte_en/read/write/write_data : command, driven by the master side
//   request_ready                         : command accepted, driven by the slave side
//   read_data/read_data_valid             : read response, driven by the slave side
//   resp_ready                            : response accepted, driven by the master side
// The arbiter takes the slave modport of an N=MASTER_NUM bundle and the
// master modport of an N=1 bundle.
interface avl_bus_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [N-1:0][ADDR_W-1:0] address;
  logic [N-1:0][BE_W-1:0]   byte_en;
  logic [N-1:0]             read;
  logic [N-1:0]             write;
  logic [N-1:0][DATA_W-1:0] write_data;
  logic [N-1:0]             request_ready;
  logic [N-1:0][DATA_W-1:0] read_data;
  logic [N-1:0]             read_data_valid;
  logic [N-1:0]             resp_ready;

  modport master (
    output address, byte_en, read, write, write_data, resp_ready,
    input  request_ready, read_data, read_data_valid
  );
  modport slave (
    input  address, byte_en, read, write, write_data, resp_ready,
    output request_ready, read_data, read_data_valid
  );
endinterface

// File: rtl/avl_bus_arbiter_id_fifo.sv
// In-order FIFO of master ids for reads that are still outstanding.
//   clk, rest : clock, async active-low reset (empties the FIFO)
//   push      : write push_id at the tail (ignored while full)
//   pop       : drop the head entry (ignored while empty)
//   head_id   : oldest id. Only meaningful while !empty.
//   count     : number of entries held
//   full      : count == DEPTH
//   empty     : count == 0
// DEPTH must be a power of two so that the pointers wrap naturally.
module avl_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rest,
  input  logic                   push,
  input  logic [ID_W-1:0]        push_id,
  input  logic                   pop,
  output logic [ID_W-1:0]        head_id,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  logic [ID_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/avl_bus_arbiter.sv
// Shares one Avalon-style slave port between MASTER_NUM masters.
//   clk, rest            : clock, async active-low reset
//   m_bus (slave mp)     : per-master commands in. request_ready is one-hot or
//                          zero. read_data is broadcast to every master.
//                          read_data_valid is one-hot at the issuing master.
//   s_bus (master mp)    : the single downstream command/response port (N=1)
//   err_unexpected_resp  : sticky. A response arrived with no read outstanding.
// Grant is combinational round-robin. A command the slave does not take at
// once locks the arbiter onto that master until it is taken. Reads are
// queued by master id so that responses route back in order.
module avl_bus_arbiter
  import avl_arb_pkg::*;
#(
  parameter int OUTSTANDING_MAX = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic              clk,
  input  logic              rest,
  avl_bus_arbiter_if.slave  m_bus,
  avl_bus_arbiter_if.master s_bus,
  output logic              err_unexpected_resp
);
  localparam int CW = $clog2(OUTSTANDING_MAX) + 1;
  localparam logic [CW-1:0] OM_C  = OUTSTANDING_MAX[CW-1:0];
  localparam logic [0:0]   S_ARB  = 1'(ARB);
  localparam logic [0:0]   S_HOLD = 1'(HOLD);

  logic [0:0]            state;
  master_id_t            rr_ptr, locked_id, gnt_id, head_id;
  logic                  gnt_vld, accept;
  logic [MASTER_NUM-1:0] req, elig;
  pick_t                 pick;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;

  // A master that sets read and write together is treated as a reader.
  // Reads need a free FIFO slot now. A pop in this cycle does not count.
  for (genvar i = 0; i < MASTER_NUM; i++) begin : g_lane
    assign req[i]  = m_bus.read[i] | m_bus.write[i];
    assign elig[i] = m_bus.read[i] ? (fifo_count < OM_C) : m_bus.write[i];
  end

  assign pick = rr_pick(elig, rr_ptr);

  // A held command is still eligible because nothing can push while locked.
  // rest gates the grant so that nothing reaches the slave while in reset.
  always_comb begin
    gnt_id  = pick.id;
    gnt_vld = rest & pick.vld;
    if (state == S_HOLD) begin
      gnt_id  = locked_id;
      gnt_vld = rest & req[locked_id];
    end
  end

  assign accept             = gnt_vld & s_bus.request_ready[0];
  assign s_bus.address      = m_bus.address[gnt_id];
  assign s_bus.byte_en      = m_bus.byte_en[gnt_id];
  assign s_bus.write_data   = m_bus.write_data[gnt_id];
  assign s_bus.read         = gnt_vld & m_bus.read[gnt_id];
  assign s_bus.write        = gnt_vld & m_bus.write[gnt_id] & ~m_bus.read[gnt_id];

  always_comb begin
    m_bus.request_ready = '0;
    if (gnt_vld) m_bus.request_ready[gnt_id] = s_bus.request_ready[0];
  end

  // Response routing. With nothing outstanding the slave is drained.
  always_comb begin
    m_bus.read_data_valid = '0;
    if (!fifo_empty) m_bus.read_data_valid[head_id] = s_bus.read_data_valid[0];
  end

  for (genvar i = 0; i < MASTER_NUM; i++) begin : g_rdata
    assign m_bus.read_data[i] = s_bus.read_data[0];
  end

  assign s_bus.resp_ready = fifo_empty ? 1'b1 : m_bus.resp_ready[head_id];
  assign fifo_push        = s_bus.read[0] & accept & ~fifo_full;
  assign fifo_pop         = s_bus.read_data_valid[0] & s_bus.resp_ready[0] & ~fifo_empty;

  avl_arb_id_fifo #(
    .DEPTH (OUTSTANDING_MAX),
    .ID_W  (MID_W)
  ) u_id_fifo (
    .clk     (clk),
    .rest    (rest),
    .push    (fifo_push),
    .push_id (gnt_id),
    .pop     (fifo_pop),
    .head_id (head_id),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state     <= S_ARB;
      rr_ptr    <= '0;
      locked_id <= '0;
    end else begin
      case (state)
        S_ARB: begin
          if (gnt_vld) begin
            if (s_bus.request_ready[0]) begin
              rr_ptr <= rr_next(gnt_id);
            end else begin
              state     <= S_HOLD;
              locked_id <= gnt_id;
            end
          end
        end
        default: begin
          if (!req[locked_id]) begin
            state <= S_ARB;
            assert (1'b0) else $error("avl_bus_arbiter: held master %0d dropped its request", locked_id);
          end else if (s_bus.request_ready[0]) begin
            state  <= S_ARB;
            rr_ptr <= rr_next(locked_id);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) err_unexpected_resp <= 1'b0;
    else if (s_bus.read_data_valid[0] && fifo_empty) err_unexpected_resp <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      for (int i = 0; i < MASTER_NUM; i++)
        assert (!(m_bus.read[i] && m_bus.write[i]))
          else $error("avl_bus_arbiter: master %0d set read and write together", i);
    end
  end
endmodule

// File: tb/tb_avl_bus_arbiter.sv
module tb_avl_bus_arbiter;
  import avl_arb_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rest = 1'b0;
  logic err;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  avl_bus_arbiter_if #(.N(MASTER_NUM), .ADDR_W(AW), .DATA_W(DW)) m_bus ();
  avl_bus_arbiter_if #(.N(1),          .ADDR_W(AW), .DATA_W(DW)) s_bus ();

  avl_bus_arbiter #(.OUTSTANDING_MAX(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                 (clk),
    .rest                (rest),
    .m_bus               (m_bus),
    .s_bus               (s_bus),
    .err_unexpected_resp (err)
  );

  task automatic idle_inputs;
    for (int i = 0; i < MASTER_NUM; i++) begin
      m_bus.address[i]    = 32'(i) * 32'h100;
      m_bus.write_data[i] = 32'hD0 + 32'(i);
      m_bus.byte_en[i]    = 4'hF;
    end
    m_bus.read              = '0;
    m_bus.write             = '0;
    m_bus.resp_ready        = '1;
    s_bus.request_ready     = '1;
    s_bus.read_data         = '0;
    s_bus.read_data_valid   = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rest = 1'b0;
    @(negedge clk);
    rest = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rest = 1'b0;
    m_bus.write = 4'b0001;
    @(negedge clk); #1;
    total++; if (m_bus.request_ready !== 4'b0000) $display("FAIL reset_req_rdy: got %b want 0000", m_bus.request_ready); else passed++;
    total++; if (s_bus.write !== 1'b0) $display("FAIL reset_s_write: got %b want 0", s_bus.write); else passed++;
    total++; if (s_bus.read !== 1'b0) $display("FAIL reset_s_read: got %b want 0", s_bus.read); else passed++;
    total++; if (m_bus.read_data_valid !== 4'b0000) $display("FAIL reset_rdv: got %b want 0000", m_bus.read_data_valid); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    m_bus.write = '0;
    @(negedge clk);
    rest = 1'b1;
  endtask

  task automatic test_rr_writes;
    logic [3:0]  exp_rdy  [4];
    logic [31:0] exp_addr [4];
    exp_rdy  = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    exp_addr = '{32'h0, 32'h200, 32'h0, 32'h200};
    do_reset();
    m_bus.write = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (m_bus.request_ready !== exp_rdy[k]) $display("FAIL rr_grant c%0d: got %b want %b", k, m_bus.request_ready, exp_rdy[k]); else passed++;
      total++; if (s_bus.address !== exp_addr[k]) $display("FAIL rr_addr c%0d: got %h want %h", k, s_bus.address, exp_addr[k]); else passed++;
      total++; if (s_bus.write !== 1'b1 || s_bus.read !== 1'b0) $display("FAIL rr_cmd c%0d: write=%b read=%b want 1/0", k, s_bus.write, s_bus.read); else passed++;
      @(negedge clk);
    end
    m_bus.write = '0;
  endtask

  task automatic test_hold;
    do_reset();
    s_bus.request_ready = 1'b0;
    m_bus.read  = 4'b0010;
    m_bus.write = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (m_bus.request_ready !== 4'b0000) $display("FAIL hold_rdy c%0d: got %b want 0000", k, m_bus.request_ready); else passed++;
      total++; if (s_bus.address !== 32'h100 || s_bus.read !== 1'b1) $display("FAIL hold_addr c%0d: addr=%h read=%b want 100/1", k, s_bus.address, s_bus.read); else passed++;
      @(negedge clk);
    end
    s_bus.request_ready = 1'b1;
    #1;
    total++; if (m_bus.request_ready !== 4'b0010) $display("FAIL hold_accept: got %b want 0010", m_bus.request_ready); else passed++;
    @(negedge clk);
    m_bus.read = '0;
    #1;
    total++; if (m_bus.request_ready !== 4'b1000) $display("FAIL hold_next: got %b want 1000", m_bus.request_ready); else passed++;
    total++; if (s_bus.address !== 32'h300 || s_bus.write !== 1'b1) $display("FAIL hold_next_cmd: addr=%h write=%b want 300/1", s_bus.address, s_bus.write); else passed++;
    @(negedge clk);
    m_bus.write = '0;
  endtask

  task automatic issue_four_reads;
    logic [3:0] mask;
    mask = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      m_bus.read = mask;
      #1;
      total++; if (m_bus.request_ready !== (4'b0001 << k) || s_bus.read !== 1'b1) $display("FAIL read_grant m%0d: rdy=%b read=%b want %b/1", k, m_bus.request_ready, s_bus.read, 4'b0001 << k); else passed++;
      @(negedge clk);
      mask[k] = 1'b0;
    end
    m_bus.read = '0;
  endtask

  task automatic test_in_order_reads;
    do_reset();
    issue_four_reads();
    for (int k = 0; k < 4; k++) begin
      s_bus.read_data_valid = 1'b1;
      s_bus.read_data       = 32'hA0 + 32'(k);
      #1;
      total++; if (m_bus.read_data_valid !== (4'b0001 << k)) $display("FAIL resp_valid r%0d: got %b want %b", k, m_bus.read_data_valid, 4'b0001 << k); else passed++;
      total++; if (m_bus.read_data[k] !== 32'hA0 + 32'(k)) $display("FAIL resp_data r%0d: got %h want %h", k, m_bus.read_data[k], 32'hA0 + 32'(k)); else passed++;
      @(negedge clk);
    end
    s_bus.read_data_valid = 1'b0;
    #1;
    total++; if (m_bus.read_data_valid !== 4'b0000 || err !== 1'b0) $display("FAIL resp_done: rdv=%b err=%b want 0000/0", m_bus.read_data_valid, err); else passed++;
  endtask

  task automatic test_full;
    do_reset();
    issue_four_reads();
    m_bus.read  = 4'b0001;
    m_bus.write = 4'b0010;
    #1;
    total++; if (m_bus.request_ready !== 4'b0010 || s_bus.write !== 1'b1) $display("FAIL full_write: rdy=%b write=%b want 0010/1", m_bus.request_ready, s_bus.write); else passed++;
    @(negedge clk);
    m_bus.write = '0;
    #1;
    total++; if (m_bus.request_ready !== 4'b0000 || s_bus.read !== 1'b0) $display("FAIL full_block: rdy=%b read=%b want 0000/0", m_bus.request_ready, s_bus.read); else passed++;
    @(negedge clk);
    s_bus.read_data_valid = 1'b1;
    s_bus.read_data       = 32'h55;
    #1;
    total++; if (m_bus.request_ready !== 4'b0000) $display("FAIL full_pop_same: got %b want 0000", m_bus.request_ready); else passed++;
    total++; if (m_bus.read_data_valid !== 4'b0001) $display("FAIL full_resp: got %b want 0001", m_bus.read_data_valid); else passed++;
    @(negedge clk);
    s_bus.read_data_valid = 1'b0;
    #1;
    total++; if (m_bus.request_ready !== 4'b0001 || s_bus.read !== 1'b1) $display("FAIL full_unblock: rdy=%b read=%b want 0001/1", m_bus.request_ready, s_bus.read); else passed++;
    @(negedge clk);
    m_bus.read = '0;
  endtask

  task automatic test_resp_backpressure;
    do_reset();
    m_bus.read = 4'b0100;
    #1;
    total++; if (m_bus.request_ready !== 4'b0100) $display("FAIL bp_grant: got %b want 0100", m_bus.request_ready); else passed++;
    @(negedge clk);
    m_bus.read            = '0;
    s_bus.read_data_valid = 1'b1;
    s_bus.read_data       = 32'h77;
    m_bus.resp_ready      = 4'b1011;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (s_bus.resp_ready !== 1'b0) $display("FAIL bp_stall c%0d: s_resp_ready=%b want 0", k, s_bus.resp_ready); else passed++;
      total++; if (m_bus.read_data_valid !== 4'b0100) $display("FAIL bp_valid c%0d: got %b want 0100", k, m_bus.read_data_valid); else passed++;
      @(negedge clk);
    end
    m_bus.resp_ready = '1;
    #1;
    total++; if (s_bus.resp_ready !== 1'b1 || m_bus.read_data_valid !== 4'b0100) $display("FAIL bp_release: rr=%b rdv=%b want 1/0100", s_bus.resp_ready, m_bus.read_data_valid); else passed++;
    @(negedge clk);
    s_bus.read_data_valid = 1'b0;
    #1;
    total++; if (err !== 1'b0) $display("FAIL bp_err: got %b want 0", err); else passed++;
    @(negedge clk);
  endtask

  task automatic test_unexpected;
    s_bus.read_data_valid = 1'b1;
    s_bus.read_data       = 32'hEE;
    #1;
    total++; if (m_bus.read_data_valid !== 4'b0000 || s_bus.resp_ready !== 1'b1) $display("FAIL unexp_drain: rdv=%b rr=%b want 0000/1", m_bus.read_data_valid, s_bus.resp_ready); else passed++;
    @(negedge clk);
    s_bus.read_data_valid = 1'b0;
    #1;
    total++; if (err !== 1'b1) $display("FAIL unexp_set: got %b want 1", err); else passed++;
    @(negedge clk); #1;
    total++; if (err !== 1'b1) $display("FAIL unexp_sticky: got %b want 1", err); else passed++;
    rest = 1'b0;
    #1;
    total++; if (err !== 1'b0) $display("FAIL unexp_clear: got %b want 0", err); else passed++;
    @(negedge clk);
    rest = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rr_writes();
    test_hold();
    test_in_order_reads();
    test_full();
    test_resp_backpressure();
    test_unexpected();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/avl_bus_arbiter.md
Name: avl_bus_arbiter

Overview:
- Shares one Avalon-style slave port between MASTER_NUM master ports.
- Round-robin grant, one command per cycle.
- Tracks outstanding reads in an in-order ID FIFO and routes each read response back to the master that issued it.
- Sits between the CPU/DMA masters and the bus slave decoder. Its slave-side traffic satisfies the one-command-per-cycle rule checked by the bus monitor.

Parameters:
- MASTER_NUM, 4: number of master ports, 2..8.
- OUTSTANDING_MAX, 4: maximum reads accepted but not yet answered, power of two, 2..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte_en width is DATA_W/8.

Ports:
- clk  in  1  clock
- rest  in  1  asynchronous active-low reset
- m_address  in  MASTER_NUM x ADDR_W  per-master address
- m_byte_en  in  MASTER_NUM x DATA_W/8  per-master byte enables
- m_read  in  MASTER_NUM  per-master read request
- m_write  in  MASTER_NUM  per-master write request
- m_write_data  in  MASTER_NUM x DATA_W  per-master write data
- m_request_ready  out  MASTER_NUM  command accepted, one-hot or zero
- m_read_data  out  MASTER_NUM x DATA_W  read data, broadcast to all masters
- m_read_data_valid  out  MASTER_NUM  response valid, one-hot or zero
- m_resp_ready  in  MASTER_NUM  per-master response ready
- s_address  out  ADDR_W  slave address
- s_byte_en  out  DATA_W/8  slave byte enables
- s_read  out  1  slave read request
- s_write  out  1  slave write request
- s_write_data  out  DATA_W  slave write data
- s_request_ready  in  1  slave accepted command
- s_read_data  in  DATA_W  slave read data
- s_read_data_valid  in  1  slave response valid
- s_resp_ready  out  1  response ready to slave
- err_unexpected_resp  out  1  sticky: response arrived with no outstanding read

Behaviour:
- Reset (rest low, asynchronous):
  - rr_ptr=0, lock=0, FIFO empty, err_unexpected_resp=0.
  - All m_request_ready, m_read_data_valid, s_read, s_write = 0.
  - Other outputs are combinational forwards and don't-care.
- Request validity:
  - Master i requests when m_read[i]|m_write[i].
  - Both set together is illegal: treated as a read; simulation $error.
- Eligibility:
  - A read-requesting master is eligible only if fifo_count < OUTSTANDING_MAX.
  - Writes are always eligible.
  - A pop in the same cycle does not unblock a read at full.
- Arbitration, state machine with two states:
  - ARB (lock=0): grant = first eligible master searching from rr_ptr upward, wrapping modulo MASTER_NUM. Grant is combinational, zero added latency.
  - Granted master's command is forwarded to s_*; s_request_ready is returned on m_request_ready[grant].
  - If no master is eligible, s_read=s_write=0.
  - ARB->HOLD: grant valid && !s_request_ready. Register locked_id=grant, lock=1.
  - ARB stays: when accepted, rr_ptr <= (grant+1) mod MASTER_NUM.
  - HOLD (lock=1): forward locked_id only, no re-arbitration. Held master must keep its request stable.
  - HOLD->ARB: on s_request_ready; rr_ptr <= locked_id+1 wrapped.
  - If the held master drops its request (protocol violation): return to ARB, $error, no transfer.
  - A held read has already passed the full check at lock time. It stays eligible because the count cannot grow while locked.
- ID FIFO:
  - Push locked/granted id on accepted read (s_read && s_request_ready).
  - Pop on s_read_data_valid && s_resp_ready && !empty.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pointers wrap modulo OUTSTANDING_MAX.
- Response routing:
  - head = FIFO head id.
  - m_read_data_valid[head] = s_read_data_valid && !empty.
  - s_resp_ready = m_resp_ready[head] when !empty, else 1 (unexpected responses are drained).
  - s_read_data goes to all m_read_data.
- s_read_data_valid while empty: err_unexpected_resp <= 1 until reset; response dropped.
- Writes create no FIFO entry and no response.
- Reset mid-transfer: lock, FIFO and pointers cleared immediately. Outstanding slave responses after reset set err_unexpected_resp.

Decomposition:
- Package avl_arb_pkg:
  - typedef master_id_t as logic[$clog2(MASTER_NUM)-1:0]. MASTER_NUM is a package localparam, overridable by redefining the package per build.
  - typedef arb_state_e {ARB, HOLD}.
  - round-robin search function rr_pick(req, ptr).
- Sub-module avl_arb_id_fifo:
  - Parameters DEPTH and ID_W.
  - Ports: push, push_id, pop, head_id, count, full, empty.

Test Plan:
- Masters 0 and 2 write continuously, slave always ready -> grants alternate 0,2,0,2; exactly one m_request_ready per cycle; no FIFO activity.
- Master 1 reads 0x100 with s_request_ready low for 3 cycles while master 3 also requests -> m_request_ready[1] on cycle 4, master 3 granted on cycle 5, s_address stable at 0x100 during the hold.
- Masters 0,1,2,3 each issue one read, slave answers in order with 0xA0..0xA3 -> valid pulses on masters 0,1,2,3 in order with matching data.
- OUTSTANDING_MAX=4, 4 reads accepted with no responses -> 5th read not granted while a write from another master proceeds; one response frees a slot and the read is accepted the following cycle.
- Slave response with head master resp_ready low for 2 cycles -> s_resp_ready low; FIFO pops only when high.
- s_read_data_valid with empty FIFO -> err_unexpected_resp=1, held until rest pulse low, then 0.
